quadrature_encoder_emulator: RTL and testbench
==============================================

Name: quadrature_encoder_emulator

Overview:
Synthesizable quadrature encoder source that drives A/B waveforms for a commanded signed number of edges at a programmable edge period. It can optionally inject contact bounce on each edge. It is the transmitter side of the wheel-encoder interface consumed by the odometry block. One instance per wheel drives A_left/B_left or A_right/B_right in hardware-in-loop benches and FPGA self-test.

Parameters:
CNT_W, 32, width of signed step command and position counter
DIV_W, 16, width of edge-period command (clock cycles per quadrature edge)
MIN_PERIOD, 4, smallest period applied; smaller requests are clamped to this
BOUNCE_LEN, 1, cycles the changing channel reverts during an injected bounce

Ports:
clk  input  1  system clock (50 MHz nominal)
reset  input  1  asynchronous, active-low reset
start  input  1  command strobe; accepted only when ready=1
steps  input  CNT_W  signed edge count; >0 = CW, <0 = CCW, 0 = null move
period  input  DIV_W  clocks between successive edges; sampled on accept
bounce_en  input  1  sampled on accept; enables bounce injection for this command
abort  input  1  stops the active command after the current clock
ready  output  1  high in IDLE
busy  output  1  high while a command is active
done  output  1  one-cycle pulse at command end
aborted  output  1  valid with done; 1 if ended by abort
A  output  1  encoder channel A (registered)
B  output  1  encoder channel B (registered)
pos  output  CNT_W  signed running edge total since reset

Behaviour:
- Reset (reset=0, async): state IDLE, A=0, B=0, pos=0, ready=1, busy=0, done=0, aborted=0. Reset mid-command kills the command immediately with no done pulse.
- States: IDLE -> RUN on start; RUN -> DONE when remaining edges reach 0 or abort=1; DONE -> IDLE after 1 cycle. A steps=0 command goes IDLE -> DONE directly.
- Accept: start=1 and ready=1 at edge t. The block latches |steps|, sign, period_eff = max(period, MIN_PERIOD) and bounce_en. ready=0 and busy=1 from t. start while busy is ignored with no queuing.
- Edge timing: first logical edge appears on A/B at edge t+period_eff. Each later edge follows period_eff cycles after the previous one.
- CW sequence (AB): 00->10->11->01->00. CCW is the reverse: 00->01->11->10->00. Exactly one channel changes per edge.
- Phase persists across commands: a new command continues from the current AB, and nothing returns AB to 00.
- pos: +1 per CW logical edge, -1 per CCW logical edge, updated on the same edge as A/B. Wraps modulo 2^CNT_W with no saturation.
- Bounce (bounce_en latched=1 and period_eff > 2*BOUNCE_LEN+1): one cycle after a logical edge, the changed channel reverts to its old value for BOUNCE_LEN cycles, then returns to the new value. The bounce does not change pos or the edge schedule. If the period condition is not met, bounce is suppressed for that command.
- done: pulses high for exactly one cycle on the edge after the last logical edge is emitted. busy=0 and ready=1 from the cycle after the done pulse. For steps=0, done pulses at t+1 with no A/B activity.
- Abort: abort=1 in RUN stops further edges, restores any in-progress bounce to the settled value, and moves to DONE with aborted=1 on done. Abort in IDLE has no effect. If abort and the final edge coincide, the final edge is emitted and aborted=1.
- Magnitude: steps = -2^(CNT_W-1) is treated as magnitude 2^(CNT_W-1), CCW. Internal down-counter is CNT_W bits unsigned.
- A and B come straight from flops with no combinational path from inputs.

Test Plan:
- Reset then start steps=+4, period=3 (clamped to 4), bounce_en=0 -> AB = 10,11,01,00 at t+4,+8,+12,+16; pos=4; done one cycle after last edge; aborted=0.
- From AB=00, pos=4, start steps=-4, period=10 -> AB = 01,11,10,00 every 10 cycles; pos returns to 0; output drives the odometry block to net-zero distance.
- steps=+3, period=10, bounce_en=1, BOUNCE_LEN=1 -> at each edge A/B shows new, old (1 cycle), new; pos=3 only; edge times unchanged; odometry sees 3 counts.
- steps=+1000, period=4, abort raised after 5 edges -> AB frozen at phase 5 mod 4 (=10), pos=5, done with aborted=1; start during busy earlier was ignored.
- steps=0 -> done at t+1, A/B and pos unchanged. steps=+2 with pos=2^31-1 (CNT_W=32) -> pos wraps to -2^31+1.
- Assert reset mid-RUN after 2 edges -> A=B=0, pos=0, no done pulse, ready=1 immediately; next command starts from AB=00.

Source files
------------

// File: rtl/quadrature_encoder_emulator_if.sv
// Command/status bundle for the quadrature encoder emulator.
// The master drives motion commands and the slave reports the encoder outputs.
interface quadrature_encoder_emulator_if #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
);
  logic             start;
  logic [CNT_W-1:0] steps;
  logic [DIV_W-1:0] period;
  logic             bounce_en;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             A;
  logic             B;
  logic [CNT_W-1:0] pos;

  modport master (
    output start, steps, period, bounce_en, abort,
    input  ready, busy, done, aborted, A, B, pos
  );

  modport slave (
    input  start, steps, period, bounce_en, abort,
    output ready, busy, done, aborted, A, B, pos
  );
endinterface

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B source: emits a signed number of edges at a fixed period,
// optionally with one contact bounce per edge, and tracks a wrapping position.
module quadrature_encoder_emulator #(
  parameter int CNT_W      = 32,
  parameter int DIV_W      = 16,
  parameter int MIN_PERIOD = 4,
  parameter int BOUNCE_LEN = 1
) (
  input logic                         clk,
  input logic                         reset,
  quadrature_encoder_emulator_if.slave bus
);

  localparam int               BW           = $clog2(BOUNCE_LEN + 2);
  localparam logic [DIV_W-1:0] MIN_P        = DIV_W'(MIN_PERIOD);
  localparam logic [DIV_W-1:0] BOUNCE_MIN   = DIV_W'(2 * BOUNCE_LEN + 1);
  localparam logic [BW-1:0]    BOUNCE_START = BW'(BOUNCE_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       out_q, out_d;
  logic [1:0]       mask_q, mask_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic             ccw_q, ccw_d;
  logic             bounceOn_q, bounceOn_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             aborted_q, aborted_d;

  logic [DIV_W-1:0] periodEff;
  logic [CNT_W-1:0] stepsMag;
  logic [1:0]       nextPh;
  logic             tick;
  logic             emit;

  function automatic logic [1:0] nextPhase(input logic [1:0] ab, input logic ccw);
    logic [1:0] cwN;
    logic [1:0] ccwN;
    case (ab)
      2'b00:   begin cwN = 2'b10; ccwN = 2'b01; end
      2'b10:   begin cwN = 2'b11; ccwN = 2'b00; end
      2'b11:   begin cwN = 2'b01; ccwN = 2'b10; end
      default: begin cwN = 2'b00; ccwN = 2'b11; end
    endcase
    return ccw ? ccwN : cwN;
  endfunction

  assign periodEff = (bus.period < MIN_P) ? MIN_P : bus.period;
  assign stepsMag  = bus.steps[CNT_W-1] ? -bus.steps : bus.steps;
  assign nextPh    = nextPhase(phase_q, ccw_q);
  assign tick      = (div_q == DIV_W'(1));

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    out_d      = out_q;
    mask_d     = mask_q;
    pos_d      = pos_q;
    left_d     = left_q;
    div_d      = div_q;
    period_d   = period_q;
    ccw_d      = ccw_q;
    bounceOn_d = bounceOn_q;
    bcnt_d     = bcnt_q;
    aborted_d  = aborted_q;
    emit       = 1'b0;

    // A running bounce shows the pre-edge level until its last cycle.
    if (bcnt_q != '0) begin
      bcnt_d = bcnt_q - BW'(1);
      out_d  = (bcnt_q == BW'(1)) ? phase_q : (phase_q ^ mask_q);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          left_d     = stepsMag;
          ccw_d      = bus.steps[CNT_W-1];
          period_d   = periodEff;
          div_d      = periodEff;
          bounceOn_d = bus.bounce_en && (periodEff > BOUNCE_MIN);
          aborted_d  = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (left_q == '0) begin
          state_d = DONE;
        end else begin
          if (tick) begin
            emit   = 1'b1;
            left_d = left_q - CNT_W'(1);
            div_d  = period_q;
          end else begin
            div_d = div_q - DIV_W'(1);
          end
          if (bus.abort) begin
            state_d   = DONE;
            aborted_d = 1'b1;
            if (!tick) begin
              out_d  = phase_q;
              bcnt_d = '0;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (emit) begin
      phase_d = nextPh;
      out_d   = nextPh;
      mask_d  = phase_q ^ nextPh;
      pos_d   = ccw_q ? (pos_q - CNT_W'(1)) : (pos_q + CNT_W'(1));
      bcnt_d  = (bounceOn_q && !bus.abort) ? BOUNCE_START : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= 2'b00;
      out_q      <= 2'b00;
      mask_q     <= 2'b00;
      pos_q      <= '0;
      left_q     <= '0;
      div_q      <= '0;
      period_q   <= '0;
      ccw_q      <= 1'b0;
      bounceOn_q <= 1'b0;
      bcnt_q     <= '0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      out_q      <= out_d;
      mask_q     <= mask_d;
      pos_q      <= pos_d;
      left_q     <= left_d;
      div_q      <= div_d;
      period_q   <= period_d;
      ccw_q      <= ccw_d;
      bounceOn_q <= bounceOn_d;
      bcnt_q     <= bcnt_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.aborted = (state_q == DONE) && aborted_q;
  assign bus.A       = out_q[1];
  assign bus.B       = out_q[0];
  assign bus.pos     = pos_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for the quadrature encoder emulator: a 32-bit instance for the
// main scenarios and a 4-bit instance to reach position wrap and the most negative step.
module tb_quadrature_encoder_emulator;

  logic clk;
  logic reset;
  int   passCnt;
  int   totalCnt;

  quadrature_encoder_emulator_if #(.CNT_W(32), .DIV_W(16)) qif ();
  quadrature_encoder_emulator_if #(.CNT_W(4),  .DIV_W(16)) sif ();

  quadrature_encoder_emulator #(.CNT_W(32), .DIV_W(16), .MIN_PERIOD(4), .BOUNCE_LEN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (qif.slave)
  );

  quadrature_encoder_emulator #(.CNT_W(4), .DIV_W(16), .MIN_PERIOD(4), .BOUNCE_LEN(1)) dutSmall (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] s, input logic [15:0] p, input logic be);
    qif.steps     = s;
    qif.period    = p;
    qif.bounce_en = be;
    qif.start     = 1'b1;
    tick(1);
    qif.start     = 1'b0;
  endtask

  task automatic applySmall(input logic [3:0] s, input logic [15:0] p);
    sif.steps     = s;
    sif.period    = p;
    sif.bounce_en = 1'b0;
    sif.start     = 1'b1;
    tick(1);
    sif.start     = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    totalCnt++;
    if (qif.ready !== 1'b1 || qif.busy !== 1'b0)
      $display("[TB] FAIL reset_status: ready=%b busy=%b expected ready=1 busy=0", qif.ready, qif.busy);
    else passCnt++;
    totalCnt++;
    if (qif.done !== 1'b0 || qif.aborted !== 1'b0)
      $display("[TB] FAIL reset_done: done=%b aborted=%b expected 0 0", qif.done, qif.aborted);
    else passCnt++;
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b00 || qif.pos !== 32'd0)
      $display("[TB] FAIL reset_outputs: AB=%b pos=%0d expected AB=00 pos=0", {qif.A, qif.B}, qif.pos);
    else passCnt++;
  endtask

  task automatic test_cw();
    logic [1:0] expAb [4];
    logic [1:0] prevAb;
    expAb  = '{2'b10, 2'b11, 2'b01, 2'b00};
    prevAb = 2'b00;
    $display("[TB] test_cw");
    applyStimulus(32'd4, 16'd3, 1'b0);
    totalCnt++;
    if (qif.busy !== 1'b1 || qif.ready !== 1'b0)
      $display("[TB] FAIL cw_accept: busy=%b ready=%b expected busy=1 ready=0", qif.busy, qif.ready);
    else passCnt++;
    for (int k = 0; k < 4; k++) begin
      tick(3);
      totalCnt++;
      if ({qif.A, qif.B} !== prevAb)
        $display("[TB] FAIL cw_hold%0d: AB=%b expected %b", k, {qif.A, qif.B}, prevAb);
      else passCnt++;
      tick(1);
      totalCnt++;
      if ({qif.A, qif.B} !== expAb[k] || qif.pos !== 32'(k + 1))
        $display("[TB] FAIL cw_edge%0d: AB=%b pos=%0d expected AB=%b pos=%0d",
                 k, {qif.A, qif.B}, qif.pos, expAb[k], k + 1);
      else passCnt++;
      prevAb = expAb[k];
    end
    tick(1);
    totalCnt++;
    if (qif.done !== 1'b1 || qif.aborted !== 1'b0)
      $display("[TB] FAIL cw_done: done=%b aborted=%b expected 1 0", qif.done, qif.aborted);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (qif.done !== 1'b0 || qif.ready !== 1'b1)
      $display("[TB] FAIL cw_idle: done=%b ready=%b expected 0 1", qif.done, qif.ready);
    else passCnt++;
  endtask

  task automatic test_ccw();
    logic [1:0] expAb [4];
    logic [1:0] prevAb;
    expAb  = '{2'b01, 2'b11, 2'b10, 2'b00};
    prevAb = 2'b00;
    $display("[TB] test_ccw");
    applyStimulus(-32'sd4, 16'd10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(9);
      totalCnt++;
      if ({qif.A, qif.B} !== prevAb)
        $display("[TB] FAIL ccw_hold%0d: AB=%b expected %b", k, {qif.A, qif.B}, prevAb);
      else passCnt++;
      tick(1);
      totalCnt++;
      if ({qif.A, qif.B} !== expAb[k] || qif.pos !== 32'(3 - k))
        $display("[TB] FAIL ccw_edge%0d: AB=%b pos=%0d expected AB=%b pos=%0d",
                 k, {qif.A, qif.B}, qif.pos, expAb[k], 3 - k);
      else passCnt++;
      prevAb = expAb[k];
    end
    tick(1);
    totalCnt++;
    if (qif.done !== 1'b1 || qif.aborted !== 1'b0)
      $display("[TB] FAIL ccw_done: done=%b aborted=%b expected 1 0", qif.done, qif.aborted);
    else passCnt++;
    tick(1);
  endtask

  task automatic test_abort();
    $display("[TB] test_abort");
    applyStimulus(32'd1000, 16'd4, 1'b0);
    tick(5);
    qif.steps = -32'sd3;
    qif.start = 1'b1;
    tick(1);
    qif.start = 1'b0;
    tick(2);
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b11 || qif.pos !== 32'd2)
      $display("[TB] FAIL abort_ignore_start: AB=%b pos=%0d expected AB=11 pos=2", {qif.A, qif.B}, qif.pos);
    else passCnt++;
    tick(12);
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b10 || qif.pos !== 32'd5)
      $display("[TB] FAIL abort_edge5: AB=%b pos=%0d expected AB=10 pos=5", {qif.A, qif.B}, qif.pos);
    else passCnt++;
    tick(2);
    qif.abort = 1'b1;
    tick(1);
    qif.abort = 1'b0;
    totalCnt++;
    if (qif.done !== 1'b1 || qif.aborted !== 1'b1)
      $display("[TB] FAIL abort_done: done=%b aborted=%b expected 1 1", qif.done, qif.aborted);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (qif.ready !== 1'b1 || {qif.A, qif.B} !== 2'b10 || qif.pos !== 32'd5)
      $display("[TB] FAIL abort_frozen: ready=%b AB=%b pos=%0d expected ready=1 AB=10 pos=5",
               qif.ready, {qif.A, qif.B}, qif.pos);
    else passCnt++;
    qif.abort = 1'b1;
    tick(1);
    qif.abort = 1'b0;
    totalCnt++;
    if (qif.ready !== 1'b1 || qif.done !== 1'b0)
      $display("[TB] FAIL abort_idle: ready=%b done=%b expected ready=1 done=0", qif.ready, qif.done);
    else passCnt++;
  endtask

  task automatic test_bounce();
    logic [1:0] newAb [3];
    logic [1:0] oldAb [3];
    newAb = '{2'b11, 2'b01, 2'b00};
    oldAb = '{2'b10, 2'b11, 2'b01};
    $display("[TB] test_bounce");
    applyStimulus(32'd3, 16'd10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick((k == 0) ? 9 : 7);
      totalCnt++;
      if ({qif.A, qif.B} !== oldAb[k])
        $display("[TB] FAIL bounce_hold%0d: AB=%b expected %b", k, {qif.A, qif.B}, oldAb[k]);
      else passCnt++;
      tick(1);
      totalCnt++;
      if ({qif.A, qif.B} !== newAb[k] || qif.pos !== 32'(6 + k))
        $display("[TB] FAIL bounce_edge%0d: AB=%b pos=%0d expected AB=%b pos=%0d",
                 k, {qif.A, qif.B}, qif.pos, newAb[k], 6 + k);
      else passCnt++;
      tick(1);
      totalCnt++;
      if ({qif.A, qif.B} !== oldAb[k] || qif.pos !== 32'(6 + k))
        $display("[TB] FAIL bounce_revert%0d: AB=%b pos=%0d expected AB=%b pos=%0d",
                 k, {qif.A, qif.B}, qif.pos, oldAb[k], 6 + k);
      else passCnt++;
      if (k == 2) begin
        totalCnt++;
        if (qif.done !== 1'b1 || qif.aborted !== 1'b0)
          $display("[TB] FAIL bounce_done: done=%b aborted=%b expected 1 0", qif.done, qif.aborted);
        else passCnt++;
      end
      tick(1);
      totalCnt++;
      if ({qif.A, qif.B} !== newAb[k])
        $display("[TB] FAIL bounce_settle%0d: AB=%b expected %b", k, {qif.A, qif.B}, newAb[k]);
      else passCnt++;
    end
    totalCnt++;
    if (qif.ready !== 1'b1 || qif.pos !== 32'd8)
      $display("[TB] FAIL bounce_end: ready=%b pos=%0d expected ready=1 pos=8", qif.ready, qif.pos);
    else passCnt++;
  endtask

  task automatic test_zero_steps();
    $display("[TB] test_zero_steps");
    applyStimulus(32'd0, 16'd8, 1'b0);
    totalCnt++;
    if (qif.busy !== 1'b1 || qif.done !== 1'b0)
      $display("[TB] FAIL zero_accept: busy=%b done=%b expected 1 0", qif.busy, qif.done);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (qif.done !== 1'b1 || qif.aborted !== 1'b0 || {qif.A, qif.B} !== 2'b00 || qif.pos !== 32'd8)
      $display("[TB] FAIL zero_done: done=%b aborted=%b AB=%b pos=%0d expected 1 0 00 8",
               qif.done, qif.aborted, {qif.A, qif.B}, qif.pos);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (qif.ready !== 1'b1 || qif.done !== 1'b0)
      $display("[TB] FAIL zero_idle: ready=%b done=%b expected 1 0", qif.ready, qif.done);
    else passCnt++;
  endtask

  task automatic test_wrap();
    $display("[TB] test_wrap");
    applySmall(4'd7, 16'd4);
    tick(28);
    totalCnt++;
    if ({sif.A, sif.B} !== 2'b01 || sif.pos !== 4'd7)
      $display("[TB] FAIL wrap_up7: AB=%b pos=%0d expected AB=01 pos=7", {sif.A, sif.B}, sif.pos);
    else passCnt++;
    tick(2);
    applySmall(4'd2, 16'd4);
    tick(8);
    totalCnt++;
    if ({sif.A, sif.B} !== 2'b10 || sif.pos !== 4'b1001)
      $display("[TB] FAIL wrap_over: AB=%b pos=%b expected AB=10 pos=1001", {sif.A, sif.B}, sif.pos);
    else passCnt++;
    tick(2);
    applySmall(4'b1000, 16'd4);
    tick(4);
    totalCnt++;
    if ({sif.A, sif.B} !== 2'b00 || sif.pos !== 4'b1000)
      $display("[TB] FAIL wrap_minneg_first: AB=%b pos=%b expected AB=00 pos=1000", {sif.A, sif.B}, sif.pos);
    else passCnt++;
    tick(28);
    totalCnt++;
    if ({sif.A, sif.B} !== 2'b10 || sif.pos !== 4'b0001)
      $display("[TB] FAIL wrap_minneg_end: AB=%b pos=%b expected AB=10 pos=0001", {sif.A, sif.B}, sif.pos);
    else passCnt++;
    tick(1);
    totalCnt++;
    if (sif.done !== 1'b1 || sif.aborted !== 1'b0)
      $display("[TB] FAIL wrap_done: done=%b aborted=%b expected 1 0", sif.done, sif.aborted);
    else passCnt++;
    tick(1);
  endtask

  task automatic test_reset_mid_run();
    logic sawDone;
    $display("[TB] test_reset_mid_run");
    applyStimulus(32'd10, 16'd4, 1'b0);
    tick(8);
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b11 || qif.pos !== 32'd10)
      $display("[TB] FAIL rst_pre: AB=%b pos=%0d expected AB=11 pos=10", {qif.A, qif.B}, qif.pos);
    else passCnt++;
    #3;
    reset = 1'b0;
    #1;
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b00 || qif.pos !== 32'd0 || qif.ready !== 1'b1 || qif.done !== 1'b0)
      $display("[TB] FAIL rst_async: AB=%b pos=%0d ready=%b done=%b expected 00 0 1 0",
               {qif.A, qif.B}, qif.pos, qif.ready, qif.done);
    else passCnt++;
    #2;
    reset = 1'b1;
    tick(1);
    sawDone = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (qif.done !== 1'b0) sawDone = 1'b1;
      tick(1);
    end
    totalCnt++;
    if (sawDone !== 1'b0)
      $display("[TB] FAIL rst_no_done: done seen=%b expected 0", sawDone);
    else passCnt++;
    applyStimulus(32'd1, 16'd4, 1'b0);
    tick(4);
    totalCnt++;
    if ({qif.A, qif.B} !== 2'b10 || qif.pos !== 32'd1)
      $display("[TB] FAIL rst_restart: AB=%b pos=%0d expected AB=10 pos=1", {qif.A, qif.B}, qif.pos);
    else passCnt++;
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passCnt       = 0;
    totalCnt      = 0;
    reset         = 1'b0;
    qif.start     = 1'b0;
    qif.steps     = '0;
    qif.period    = '0;
    qif.bounce_en = 1'b0;
    qif.abort     = 1'b0;
    sif.start     = 1'b0;
    sif.steps     = '0;
    sif.period    = '0;
    sif.bounce_en = 1'b0;
    sif.abort     = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    test_reset();
    test_cw();
    test_ccw();
    test_abort();
    test_bounce();
    test_zero_steps();
    test_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
